// File: rtl/system_onchip_memory2_pkg.sv
// rtl/system_onchip_memory2_pkg.sv - shared types and constants for the dual-port on-chip memory
package system_onchip_memory2_pkg;
  typedef enum logic {CLEAR, READY} state_t;

  // On a same-address write collision the s1 write is kept.
  localparam bit S1_WINS = 1'b1;

  function automatic bit latency_ok(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction
endpackage

// File: rtl/system_onchip_memory2_tdp_ram.sv
// rtl/system_onchip_memory2_tdp_ram.sv - true dual-port byte-enabled RAM, read-before-write on both ports
module system_onchip_memory2_tdp_ram #(
  parameter int    DATA_WIDTH = 32,
  parameter int    DEPTH      = 64000,
  parameter int    AW         = 16,
  parameter string INIT_FILE  = ""
) (
  input  logic                    clk,
  input  logic                    ce,
  input  logic                    we_a,
  input  logic [DATA_WIDTH/8-1:0] be_a,
  input  logic [AW-1:0]           addr_a,
  input  logic [DATA_WIDTH-1:0]   wdata_a,
  output logic [DATA_WIDTH-1:0]   q_a,
  input  logic                    we_b,
  input  logic [DATA_WIDTH/8-1:0] be_b,
  input  logic [AW-1:0]           addr_b,
  input  logic [DATA_WIDTH-1:0]   wdata_b,
  output logic [DATA_WIDTH-1:0]   q_b
);
  localparam int BW = DATA_WIDTH / 8;

  (* ram_init_file = INIT_FILE *)
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Reads sample the array before this edge's writes land, giving old data on a same-cycle hit.
  always_ff @(posedge clk) begin
    if (ce) begin
      q_a <= mem[addr_a];
      q_b <= mem[addr_b];
      for (int i = 0; i < BW; i++) begin
        if (we_a && be_a[i]) mem[addr_a][8*i +: 8] <= wdata_a[8*i +: 8];
        if (we_b && be_b[i]) mem[addr_b][8*i +: 8] <= wdata_b[8*i +: 8];
      end
    end
  end
endmodule

// File: rtl/system_onchip_memory2_dp.sv
// rtl/system_onchip_memory2_dp.sv - dual Avalon-MM slave on-chip memory with post-reset clear sweep
module system_onchip_memory2_dp
  import system_onchip_memory2_pkg::*;
#(
  parameter int    DATA_WIDTH     = 32,
  parameter int    ADDR_WIDTH     = 16,
  parameter int    DEPTH          = 64000,
  parameter int    READ_LATENCY   = 1,
  parameter bit    CLEAR_ON_RESET = 1'b1,
  parameter string INIT_FILE      = "system_onchip_memory2_dp.hex"
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic                    reset_req,
  input  logic                    freeze,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  output logic                    s1_waitrequest,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  output logic                    s2_waitrequest
);
  localparam int BW = DATA_WIDTH / 8;
  localparam int AW = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  if (!latency_ok(READ_LATENCY)) begin : g_bad_latency
    $error("READ_LATENCY must be 1 or 2");
  end

  state_t        state;
  logic [AW-1:0] clr_cnt;
  logic          en, waitreq, clearing, collide;

  assign en       = clken & ~reset_req;
  assign clearing = (state == CLEAR);
  assign waitreq  = clearing | ~en;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR_ON_RESET ? CLEAR : READY;
      clr_cnt <= '0;
    end else if (en && clearing) begin
      if (clr_cnt == AW'(DEPTH - 1)) state <= READY;
      else clr_cnt <= clr_cnt + AW'(1);
    end
  end

  // Index 0 is s1, index 1 is s2.
  logic [1:0][ADDR_WIDTH-1:0] addr;
  logic [1:0][BW-1:0]         be;
  logic [1:0][DATA_WIDTH-1:0] wdata, q, rdata;
  logic [1:0]                 cs, rd, wr, in_range, rd_acc, wr_ok, we, rvalid;

  assign addr  = {s2_address, s1_address};
  assign be    = {s2_byteenable, s1_byteenable};
  assign wdata = {s2_writedata, s1_writedata};
  assign cs    = {s2_chipselect, s1_chipselect};
  assign rd    = {s2_read, s1_read};
  assign wr    = {s2_write, s1_write};

  assign collide = wr_ok[0] & wr_ok[1] & (addr[0] == addr[1]);
  assign we[0]   = wr_ok[0] & ~(collide & ~S1_WINS);
  assign we[1]   = wr_ok[1] & ~(collide & S1_WINS);

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic v1, oor1;

    assign in_range[p] = {1'b0, addr[p]} < DEPTH_W;
    assign rd_acc[p]   = cs[p] & rd[p] & ~wr[p] & ~waitreq;
    assign wr_ok[p]    = cs[p] & wr[p] & ~waitreq & in_range[p] & ~freeze;

    always_ff @(posedge clk) begin
      if (reset) begin
        v1   <= 1'b0;
        oor1 <= 1'b0;
      end else if (en) begin
        v1   <= rd_acc[p];
        oor1 <= ~in_range[p];
      end
    end

    // The strobe is gated by en so a response held through a stall is presented exactly once.
    if (READ_LATENCY == 1) begin : g_lat1
      logic [DATA_WIDTH-1:0] hold;
      assign rvalid[p] = v1 & en;
      assign rdata[p]  = rvalid[p] ? (oor1 ? '0 : q[p]) : hold;
      always_ff @(posedge clk) begin
        if (reset)   hold <= '0;
        else if (en) hold <= rdata[p];
      end
    end else begin : g_lat2
      logic                  v2;
      logic [DATA_WIDTH-1:0] d2;
      assign rvalid[p] = v2 & en;
      assign rdata[p]  = d2;
      always_ff @(posedge clk) begin
        if (reset) begin
          v2 <= 1'b0;
          d2 <= '0;
        end else if (en) begin
          v2 <= v1;
          if (v1) d2 <= oor1 ? '0 : q[p];
        end
      end
    end
  end

  system_onchip_memory2_tdp_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .AW        (AW),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk    (clk),
    .ce     (en),
    .we_a   (clearing | we[0]),
    .be_a   (clearing ? {BW{1'b1}} : be[0]),
    .addr_a (clearing ? clr_cnt : addr[0][AW-1:0]),
    .wdata_a(clearing ? '0 : wdata[0]),
    .q_a    (q[0]),
    .we_b   (we[1]),
    .be_b   (be[1]),
    .addr_b (addr[1][AW-1:0]),
    .wdata_b(wdata[1]),
    .q_b    (q[1])
  );

  assign s1_readdata      = rdata[0];
  assign s2_readdata      = rdata[1];
  assign s1_readdatavalid = rvalid[0];
  assign s2_readdatavalid = rvalid[1];
  assign s1_waitrequest   = waitreq;
  assign s2_waitrequest   = waitreq;
endmodule

// File: tb/tb_system_onchip_memory2_dp.sv
// tb/tb_system_onchip_memory2_dp.sv - randomized self-checking bench for the dual-port on-chip memory
module tb_system_onchip_memory2_dp;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int DEPTH = 16;
  localparam int RL = 1;

  logic clk = 1'b0, reset = 1'b1, clken = 1'b1, reset_req = 1'b0, freeze = 1'b0;
  logic [AW-1:0] s1_address = '0, s2_address = '0;
  logic [3:0] s1_byteenable = '0, s2_byteenable = '0;
  logic s1_chipselect = 1'b0, s1_read = 1'b0, s1_write = 1'b0;
  logic s2_chipselect = 1'b0, s2_read = 1'b0, s2_write = 1'b0;
  logic [DW-1:0] s1_writedata = '0, s2_writedata = '0;
  logic [DW-1:0] s1_readdata, s2_readdata;
  logic s1_readdatavalid, s2_readdatavalid, s1_waitrequest, s2_waitrequest;

  int n_cmp = 0, n_bad = 0;
  logic [DW-1:0] model [DEPTH];

  always #5 clk = ~clk;

  system_onchip_memory2_dp #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(RL),
    .CLEAR_ON_RESET(1'b1), .INIT_FILE("")
  ) dut (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req), .freeze(freeze),
    .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
    .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
    .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid), .s1_waitrequest(s1_waitrequest),
    .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
    .s2_read(s2_read), .s2_write(s2_write), .s2_writedata(s2_writedata),
    .s2_readdata(s2_readdata), .s2_readdatavalid(s2_readdatavalid), .s2_waitrequest(s2_waitrequest)
  );

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [3:0] b);
    logic [DW-1:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{b[i]}};
    return (old & ~m) | (d & m);
  endfunction

  function automatic logic [DW-1:0] expect_rd(input int a);
    return (a < DEPTH) ? model[a] : '0;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic idle();
    s1_chipselect = 1'b0; s1_read = 1'b0; s1_write = 1'b0;
    s2_chipselect = 1'b0; s2_read = 1'b0; s2_write = 1'b0;
  endtask

  task automatic drive(input int p, input logic r, input logic w, input int a,
                       input logic [DW-1:0] d, input logic [3:0] b);
    if (p == 0) begin
      s1_chipselect = 1'b1; s1_read = r; s1_write = w;
      s1_address = AW'(a); s1_writedata = d; s1_byteenable = b;
    end else begin
      s2_chipselect = 1'b1; s2_read = r; s2_write = w;
      s2_address = AW'(a); s2_writedata = d; s2_byteenable = b;
    end
  endtask

  task automatic do_write(input int p, input int a, input logic [DW-1:0] d, input logic [3:0] b);
    @(posedge clk); #1; idle(); drive(p, 1'b0, 1'b1, a, d, b);
    @(posedge clk); #1; idle();
  endtask

  // Issues one read and observes 6 cycles after acceptance: first-response cycle, data, pulse count.
  task automatic do_read(input int p, input int a, output logic [DW-1:0] data,
                         output int lat, output int pulses);
    @(posedge clk); #1; idle(); drive(p, 1'b1, 1'b0, a, '0, 4'h0);
    @(posedge clk); #1; idle();
    lat = 0; pulses = 0; data = '0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if ((p == 0) ? s1_readdatavalid : s2_readdatavalid) begin
        pulses++;
        if (lat == 0) begin
          lat = k;
          data = (p == 0) ? s1_readdata : s2_readdata;
        end
      end
    end
  endtask

  task automatic count_clear(output int n);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (!s1_waitrequest) break;
      n++;
    end
  endtask

  task automatic test_reset();
    int n, lat, pulses;
    logic [DW-1:0] d;
    reset = 1'b1; idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (s1_waitrequest !== 1'b1 || s2_waitrequest !== 1'b1) begin
      n_bad++; $display("FAIL reset_waitreq got=%b%b exp=11", s1_waitrequest, s2_waitrequest); end
    n_cmp++; if (s1_readdatavalid !== 1'b0 || s2_readdatavalid !== 1'b0) begin
      n_bad++; $display("FAIL reset_valid got=%b%b exp=00", s1_readdatavalid, s2_readdatavalid); end
    n_cmp++; if (s1_readdata !== '0 || s2_readdata !== '0) begin
      n_bad++; $display("FAIL reset_readdata got=%h/%h exp=0", s1_readdata, s2_readdata); end
    @(posedge clk); #1; reset = 1'b0;
    count_clear(n);
    clear_model();
    n_cmp++; if (n !== DEPTH) begin
      n_bad++; $display("FAIL clear_length got=%0d exp=%0d", n, DEPTH); end
    for (int a = 0; a < DEPTH; a++) begin
      do_read(a % 2, a, d, lat, pulses);
      n_cmp++; if (d !== 32'h0 || lat !== RL || pulses !== 1) begin
        n_bad++; $display("FAIL cleared_read addr=%0d got=%h/lat%0d/n%0d exp=0/lat%0d/n1", a, d, lat, pulses, RL); end
    end
  endtask

  task automatic test_byteenable();
    int lat, pulses, p, a;
    logic [DW-1:0] d, wd;
    logic [3:0] b;
    do_write(0, 3, 32'hDEADBEEF, 4'b0101);
    model[3] = merge(model[3], 32'hDEADBEEF, 4'b0101);
    do_read(1, 3, d, lat, pulses);
    n_cmp++; if (d !== 32'h00AD00EF || lat !== RL || pulses !== 1) begin
      n_bad++; $display("FAIL be_fixed got=%h/lat%0d/n%0d exp=00ad00ef/lat%0d/n1", d, lat, pulses, RL); end
    for (int i = 0; i < 24; i++) begin
      p = $urandom_range(0, 1); a = $urandom_range(0, DEPTH - 1);
      wd = $urandom; b = 4'($urandom_range(0, 15));
      do_write(p, a, wd, b);
      model[a] = merge(model[a], wd, b);
      a = $urandom_range(0, DEPTH - 1);
      do_read($urandom_range(0, 1), a, d, lat, pulses);
      n_cmp++; if (d !== expect_rd(a) || lat !== RL) begin
        n_bad++; $display("FAIL be_random addr=%0d got=%h/lat%0d exp=%h/lat%0d", a, d, lat, expect_rd(a), RL); end
    end
  endtask

  task automatic write_both(input int a1, input logic [DW-1:0] d1, input logic [3:0] b1,
                            input int a2, input logic [DW-1:0] d2, input logic [3:0] b2);
    @(posedge clk); #1; idle();
    drive(0, 1'b0, 1'b1, a1, d1, b1);
    drive(1, 1'b0, 1'b1, a2, d2, b2);
    @(posedge clk); #1; idle();
  endtask

  task automatic test_collision();
    int lat, pulses, a, a2;
    logic [DW-1:0] d, d1, d2;
    logic [3:0] b1, b2;
    write_both(5, 32'h11111111, 4'hF, 5, 32'h22222222, 4'hF);
    model[5] = 32'h11111111;
    do_read(1, 5, d, lat, pulses);
    n_cmp++; if (d !== 32'h11111111) begin
      n_bad++; $display("FAIL collide_fixed got=%h exp=11111111", d); end
    for (int i = 0; i < 6; i++) begin
      a = $urandom_range(0, DEPTH - 1);
      a2 = (i % 2 == 0) ? a : (a + 1 + $urandom_range(0, DEPTH - 2)) % DEPTH;
      d1 = $urandom; d2 = $urandom;
      b1 = 4'($urandom_range(0, 15)); b2 = 4'($urandom_range(0, 15));
      write_both(a, d1, b1, a2, d2, b2);
      model[a] = merge(model[a], d1, b1);
      if (a2 != a) model[a2] = merge(model[a2], d2, b2);
      do_read(0, a, d, lat, pulses);
      n_cmp++; if (d !== expect_rd(a)) begin
        n_bad++; $display("FAIL collide_s1 addr=%0d got=%h exp=%h", a, d, expect_rd(a)); end
      do_read(1, a2, d, lat, pulses);
      n_cmp++; if (d !== expect_rd(a2)) begin
        n_bad++; $display("FAIL collide_s2 addr=%0d got=%h exp=%h", a2, d, expect_rd(a2)); end
    end
  endtask

  task automatic test_read_before_write();
    int a, lat, pulses, rp;
    logic [DW-1:0] d, wd, old;
    logic got;
    for (int wp = 0; wp < 2; wp++) begin
      rp = 1 - wp; a = $urandom_range(0, DEPTH - 1); wd = $urandom; old = expect_rd(a);
      @(posedge clk); #1; idle();
      drive(wp, 1'b0, 1'b1, a, wd, 4'hF);
      drive(rp, 1'b1, 1'b0, a, '0, 4'h0);
      @(posedge clk); #1; idle();
      model[a] = wd;
      got = 1'b0; d = '0;
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk);
        if (!got && ((rp == 0) ? s1_readdatavalid : s2_readdatavalid)) begin
          got = 1'b1; d = (rp == 0) ? s1_readdata : s2_readdata;
        end
      end
      n_cmp++; if (!got || d !== old) begin
        n_bad++; $display("FAIL rbw_old wp=%0d addr=%0d got=%h valid=%b exp=%h", wp, a, d, got, old); end
      do_read(rp, a, d, lat, pulses);
      n_cmp++; if (d !== wd) begin
        n_bad++; $display("FAIL rbw_new addr=%0d got=%h exp=%h", a, d, wd); end
    end
  endtask

  task automatic test_stall();
    int a, first, pulses;
    logic [DW-1:0] d;
    a = $urandom_range(0, DEPTH - 1);
    @(posedge clk); #1; idle(); drive(0, 1'b1, 1'b0, a, '0, 4'h0);
    @(posedge clk); #1; idle(); clken = 1'b0;
    first = 0; pulses = 0; d = '0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (s1_readdatavalid) pulses++;
      n_cmp++; if (s1_waitrequest !== 1'b1 || s2_waitrequest !== 1'b1) begin
        n_bad++; $display("FAIL stall_waitreq k=%0d got=%b%b exp=11", k, s1_waitrequest, s2_waitrequest); end
    end
    @(posedge clk); #1; clken = 1'b1;
    for (int k = 4; k <= 9; k++) begin
      @(negedge clk);
      if (s1_readdatavalid) begin
        pulses++;
        if (first == 0) begin first = k; d = s1_readdata; end
      end
    end
    n_cmp++; if (first !== RL + 3 || pulses !== 1) begin
      n_bad++; $display("FAIL stall_timing got=k%0d/n%0d exp=k%0d/n1", first, pulses, RL + 3); end
    n_cmp++; if (d !== expect_rd(a)) begin
      n_bad++; $display("FAIL stall_data addr=%0d got=%h exp=%h", a, d, expect_rd(a)); end
  endtask

  task automatic test_reset_discard();
    int n, pulses;
    @(posedge clk); #1; idle(); drive(1, 1'b1, 1'b0, $urandom_range(0, DEPTH - 1), '0, 4'h0);
    if (RL == 1) reset = 1'b1;
    @(posedge clk); #1; idle(); reset = 1'b1;
    pulses = 0;
    @(negedge clk); if (s2_readdatavalid) pulses++;
    @(posedge clk); #1; reset = 1'b0;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (s2_readdatavalid) pulses++;
      if (!s2_waitrequest) break;
      n++;
    end
    clear_model();
    n_cmp++; if (pulses !== 0) begin
      n_bad++; $display("FAIL discard_pending got=%0d pulses exp=0", pulses); end
    n_cmp++; if (n !== DEPTH) begin
      n_bad++; $display("FAIL discard_clear_length got=%0d exp=%0d", n, DEPTH); end
    n_cmp++; if (s2_readdata !== '0) begin
      n_bad++; $display("FAIL discard_readdata got=%h exp=0", s2_readdata); end
  endtask

  task automatic test_reset_mid_clear();
    int n, lat, pulses;
    logic [DW-1:0] d;
    do_write(0, 9, 32'hC0FFEE09, 4'hF);
    do_write(1, 15, 32'h0BADF00D, 4'hF);
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    repeat (7) @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    count_clear(n);
    clear_model();
    n_cmp++; if (n !== DEPTH) begin
      n_bad++; $display("FAIL midclear_length got=%0d exp=%0d", n, DEPTH); end
    foreach (model[a]) begin
      do_read(a % 2, a, d, lat, pulses);
      n_cmp++; if (d !== 32'h0) begin
        n_bad++; $display("FAIL midclear_read addr=%0d got=%h exp=0", a, d); end
    end
  endtask

  task automatic test_freeze_oor();
    int lat, pulses;
    logic [DW-1:0] d;
    freeze = 1'b1;
    do_write(0, 2, 32'hAAAAAAAA, 4'hF);
    do_write(1, 6, 32'h55555555, 4'hF);
    freeze = 1'b0;
    do_read(1, 2, d, lat, pulses);
    n_cmp++; if (d !== 32'h0) begin
      n_bad++; $display("FAIL freeze_s1 got=%h exp=0", d); end
    do_read(0, 6, d, lat, pulses);
    n_cmp++; if (d !== expect_rd(6)) begin
      n_bad++; $display("FAIL freeze_s2 got=%h exp=%h", d, expect_rd(6)); end
    do_write(0, 20, 32'h12345678, 4'hF);
    do_write(1, 4 + DEPTH * 2, 32'h87654321, 4'hF);
    do_read(1, 20, d, lat, pulses);
    n_cmp++; if (d !== 32'h0 || lat !== RL || pulses !== 1) begin
      n_bad++; $display("FAIL oor_read got=%h/lat%0d/n%0d exp=0/lat%0d/n1", d, lat, pulses, RL); end
    do_read(0, 16'hFFFF, d, lat, pulses);
    n_cmp++; if (d !== 32'h0 || lat !== RL) begin
      n_bad++; $display("FAIL oor_top got=%h/lat%0d exp=0/lat%0d", d, lat, RL); end
    do_read(0, 4, d, lat, pulses);
    n_cmp++; if (d !== expect_rd(4)) begin
      n_bad++; $display("FAIL oor_alias got=%h exp=%h", d, expect_rd(4)); end
  endtask

  task automatic test_back_to_back();
    localparam int N = 12;
    int a1[N], a2[N];
    int j;
    logic [DW-1:0] wd;
    for (int a = 0; a < DEPTH; a++) begin
      wd = $urandom;
      do_write(a % 2, a, wd, 4'hF);
      model[a] = wd;
    end
    for (int i = 0; i < N; i++) begin
      a1[i] = ($urandom_range(0, 5) == 0) ? $urandom_range(DEPTH, 40) : $urandom_range(0, DEPTH - 1);
      a2[i] = $urandom_range(0, DEPTH - 1);
    end
    @(posedge clk); #1; idle();
    drive(0, 1'b1, 1'b0, a1[0], '0, 4'h0);
    drive(1, 1'b1, 1'b0, a2[0], '0, 4'h0);
    for (int c = 0; c < N + RL + 1; c++) begin
      @(posedge clk); #1; idle();
      if (c + 1 < N) begin
        drive(0, 1'b1, 1'b0, a1[c+1], '0, 4'h0);
        drive(1, 1'b1, 1'b0, a2[c+1], '0, 4'h0);
      end
      @(negedge clk);
      j = c - (RL - 1);
      if (j >= 0 && j < N) begin
        n_cmp++; if (s1_readdatavalid !== 1'b1 || s1_readdata !== expect_rd(a1[j])) begin
          n_bad++; $display("FAIL b2b_s1 idx=%0d got=%b/%h exp=1/%h", j, s1_readdatavalid, s1_readdata, expect_rd(a1[j])); end
        n_cmp++; if (s2_readdatavalid !== 1'b1 || s2_readdata !== expect_rd(a2[j])) begin
          n_bad++; $display("FAIL b2b_s2 idx=%0d got=%b/%h exp=1/%h", j, s2_readdatavalid, s2_readdata, expect_rd(a2[j])); end
      end else begin
        n_cmp++; if (s1_readdatavalid !== 1'b0 || s2_readdatavalid !== 1'b0) begin
          n_bad++; $display("FAIL b2b_idle cycle=%0d got=%b%b exp=00", c, s1_readdatavalid, s2_readdatavalid); end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_byteenable();
    test_collision();
    test_read_before_write();
    test_stall();
    test_reset_discard();
    test_reset_mid_clear();
    test_freeze_oor();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/system_onchip_memory2_dp.md
# system_onchip_memory2_dp

Parametrised true-dual-port on-chip memory with two independent Avalon-MM slaves (s1, s2) on one clock, byte enables, and configurable read latency with readdatavalid. An optional post-reset clear sweep zeroes the array, with waitrequest held high while it runs. It sits on the system interconnect as shared scratch/message memory between two masters (e.g. two SHA cores, or a CPU and a DMA).

## Interface
- DATA_WIDTH, 32, word width; a multiple of 8.
- ADDR_WIDTH, 16, word-address width.
- DEPTH, 64000, number of words; must be ≤ 2**ADDR_WIDTH.
- READ_LATENCY, 1, read latency: 1 (RAM output) or 2 (extra output register).
- CLEAR_ON_RESET, 1, when 1, zero all words after reset.
- INIT_FILE, "system_onchip_memory2_dp.hex", power-up contents.

Ports:
- clk  in  1  clock. One clock; reset is synchronous and active-high.
- reset  in  1  synchronous active-high reset.
- clken  in  1  global clock enable.
- reset_req  in  1  when high, acts as clken low.
- freeze  in  1  when high, suppresses all writes from both slaves.
- sN_address  in  ADDR_WIDTH  word address (N = 1, 2; same set of ports per slave).
- sN_byteenable  in  DATA_WIDTH/8  byte lanes to write.
- sN_chipselect, sN_read, sN_write  in  1  Avalon-MM strobes.
- sN_writedata  in  DATA_WIDTH  write data.
- sN_readdata  out  DATA_WIDTH  read data.
- sN_readdatavalid  out  1  read response strobe.
- sN_waitrequest  out  1  command stall.

## Operation
- FSM states: CLEAR, READY.
  - Reset enters CLEAR if CLEAR_ON_RESET=1, otherwise READY.
  - In CLEAR, clr_cnt walks from 0 to DEPTH-1, writing all-zero full words through port A, one word per enabled cycle.
  - After address DEPTH-1 is written, the next cycle enters READY.
  - When CLEAR_ON_RESET=0, INIT_FILE contents survive reset.
- en = clken & ~reset_req.
- sN_waitrequest = (state==CLEAR) | ~en.
- A command is accepted when chipselect & (read|write) & ~waitrequest.
- Write: byte lanes with byteenable set are updated. The write is dropped if freeze=1 or address ≥ DEPTH.
- Read: a response is issued exactly READ_LATENCY cycles after acceptance, as one readdatavalid pulse. readdata holds its last value between responses.
  - Address ≥ DEPTH returns 0 with valid.
- read & write asserted together: treated as a write only; no response.
- Both slaves write the same address in one cycle: s1 wins; the s2 write is dropped entirely, regardless of byteenable overlap.
- A read of an address written the same cycle (either port) returns the old data (read-before-write).
- en low freezes the RAM, the FSM, clr_cnt and the response pipeline. In-flight responses are delayed, not lost.

## Timing
- Reset values:
  - readdata = 0, readdatavalid = 0.
  - waitrequest = 1 if CLEAR_ON_RESET, else 0.
  - clr_cnt = 0.
- Reset mid-CLEAR restarts the clear at address 0.
- Reset while READY discards all pending responses.
- Clear duration: DEPTH enabled cycles. waitrequest falls in the cycle the FSM reaches READY.
- Back-to-back reads on each slave, every cycle: full throughput, no bubbles.
- Ports are fully independent; there is no arbitration stall.

## Structure
- Package system_onchip_memory2_pkg holds:
  - the state enum (CLEAR, READY);
  - the READ_LATENCY legality check;
  - the collision-priority constant (S1_WINS).
- Sub-module system_onchip_memory2_tdp_ram: an inferred true-dual-port, byte-enabled, read-before-write RAM with INIT_FILE and a clock enable.
- Top level contains the FSM, clear mux onto port A, address-range checks, collision gating and readdatavalid shift registers.

## Test plan
- Bench parameters: DEPTH=16, DATA_WIDTH=32, CLEAR_ON_RESET=1.
  - Reset → waitrequest high for exactly 16 cycles. Reads of all 16 addresses then return 0x00000000.
- s1 writes 0xDEADBEEF to addr 3 with byteenable 0b0101. The addr 3 read from s2 after clear returns 0x00AD00EF, valid at T+1 (READ_LATENCY=1) and at T+2 (READ_LATENCY=2).
- Same cycle: s1 writes 0x11111111 and s2 writes 0x22222222 to addr 5. Readback = 0x11111111.
- clken low for 3 cycles with a read in flight. readdatavalid is delayed by 3 cycles and fires exactly once. waitrequest is high during the stall.
- Reset asserted at clear count 7 → clear restarts from 0 and lasts 16 cycles. A pending READY-state read is discarded, with no readdatavalid.
- freeze=1 write of 0xAAAAAAAA to addr 2 leaves 0. Write to addr 20 is dropped, and a read of addr 20 returns 0 with valid.
